// File: rtl/calc_fsm_param.sv
// Keypad calculator FSM with multi-digit entry, left-to-right operator chaining,
// a WIDTH-cycle restoring divider and a sticky divide-by-zero error state.
module calc_fsm_param #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             num_valid,
  input  logic [3:0]       button_num,
  input  logic             op_valid,
  input  logic [2:0]       button_op,
  input  logic             equal,
  output logic [WIDTH-1:0] result_temp,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             error,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] S_ENTER  = 3'd0;
  localparam logic [2:0] S_OPWAIT = 3'd1;
  localparam logic [2:0] S_DIVIDE = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int DIV_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2:0]       state;
  logic [2:0]       op;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] entry;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_dvsr;
  logic [DIV_W-1:0] div_cnt;
  logic             div_to_done;

  // Key strobes are single-cycle pulses with no ready/back-pressure: a strobe is
  // consumed on the edge it is seen, or dropped (busy, error, lower priority, bad code).
  logic key_eq, key_op, key_num, op_ok, digit_ok;
  logic [WIDTH-1:0] entry_next, arith_val;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next, div_q_next;

  always_comb begin
    key_eq     = equal;
    key_op     = op_valid & ~equal;
    key_num    = num_valid & ~equal & ~op_valid;
    op_ok      = (button_op >= OP_ADD) && (button_op <= OP_DIV);
    digit_ok   = (button_num <= 4'd9);
    entry_next = entry * WIDTH'(10) + WIDTH'(button_num);
    case (op)
      OP_ADD:  arith_val = acc + entry;
      OP_SUB:  arith_val = acc - entry;
      OP_MUL:  arith_val = acc * entry;
      default: arith_val = entry;
    endcase
    // One restoring step: the difference always fits in WIDTH bits when div_ge holds.
    div_shift    = {div_rem, div_q[WIDTH-1]};
    div_ge       = (div_shift >= {1'b0, div_dvsr});
    div_rem_next = div_ge ? (div_shift[WIDTH-1:0] - div_dvsr) : div_shift[WIDTH-1:0];
    div_q_next   = {div_q[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= S_ENTER;
      op          <= OP_NONE;
      acc         <= '0;
      entry       <= '0;
      count       <= '0;
      result      <= '0;
      div_q       <= '0;
      div_rem     <= '0;
      div_dvsr    <= '0;
      div_cnt     <= '0;
      div_to_done <= 1'b0;
    end else begin
      case (state)
        S_ENTER, S_OPWAIT: begin
          if (key_eq) begin
            if (state == S_OPWAIT) begin
              result <= acc;
              op     <= OP_NONE;
              state  <= S_DONE;
            end else if (op == OP_DIV) begin
              if (entry == '0) begin
                result <= '0;
                state  <= S_ERROR;
              end else begin
                div_q       <= acc;
                div_rem     <= '0;
                div_dvsr    <= entry;
                div_cnt     <= '0;
                div_to_done <= 1'b1;
                op          <= OP_NONE;
                entry       <= '0;
                count       <= '0;
                state       <= S_DIVIDE;
              end
            end else begin
              acc    <= arith_val;
              result <= arith_val;
              op     <= OP_NONE;
              state  <= S_DONE;
            end
          end else if (key_op && op_ok) begin
            if (state == S_OPWAIT) begin
              op <= button_op;
            end else if (op == OP_DIV) begin
              if (entry == '0) begin
                result <= '0;
                state  <= S_ERROR;
              end else begin
                div_q       <= acc;
                div_rem     <= '0;
                div_dvsr    <= entry;
                div_cnt     <= '0;
                div_to_done <= 1'b0;
                op          <= button_op;
                entry       <= '0;
                count       <= '0;
                state       <= S_DIVIDE;
              end
            end else begin
              acc   <= arith_val;
              op    <= button_op;
              entry <= '0;
              count <= '0;
              state <= S_OPWAIT;
            end
          end else if (key_num && digit_ok && (count < CNT_W'(MAX_DIGITS))) begin
            entry <= entry_next;
            count <= count + CNT_W'(1);
            state <= S_ENTER;
          end
        end
        S_DIVIDE: begin
          div_q   <= div_q_next;
          div_rem <= div_rem_next;
          div_cnt <= div_cnt + DIV_W'(1);
          if (div_cnt == DIV_W'(WIDTH - 1)) begin
            acc <= div_q_next;
            if (div_to_done) begin
              result <= div_q_next;
              state  <= S_DONE;
            end else begin
              state <= S_OPWAIT;
            end
          end
        end
        S_DONE: begin
          if (key_eq) begin
            state <= S_DONE;
          end else if (key_op && op_ok) begin
            acc   <= result;
            op    <= button_op;
            entry <= '0;
            count <= '0;
            state <= S_OPWAIT;
          end else if (key_num && digit_ok) begin
            acc   <= '0;
            entry <= WIDTH'(button_num);
            count <= CNT_W'(1);
            op    <= OP_NONE;
            state <= S_ENTER;
          end
        end
        default: state <= S_ERROR;
      endcase
    end
  end

  always_comb begin
    case (state)
      S_ENTER:            result_temp = entry;
      S_OPWAIT, S_DIVIDE: result_temp = acc;
      S_DONE:             result_temp = result;
      default:            result_temp = '0;
    endcase
    busy      = (state == S_DIVIDE);
    error     = (state == S_ERROR);
    state_dbg = state;
  end

endmodule

// File: tb/tb_calc_fsm_param.sv
// Directed plus randomised bench for calc_fsm_param with a queue-based scoreboard.
module tb_calc_fsm_param;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         clear, num_valid, op_valid, equal;
  logic [3:0]   button_num;
  logic [2:0]   button_op;
  logic [W-1:0] result_temp, result;
  logic         busy, error;
  logic [2:0]   state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  calc_fsm_param #(.WIDTH(W), .MAX_DIGITS(4)) dut (
    .clk(clk), .clear(clear), .num_valid(num_valid), .button_num(button_num),
    .op_valid(op_valid), .button_op(button_op), .equal(equal),
    .result_temp(result_temp), .result(result), .busy(busy), .error(error),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Drivers: entered just after a falling edge, leave just after the next one.
  task automatic press_num(input logic [3:0] d);
    num_valid = 1'b1; button_num = d;
    @(negedge clk);
    num_valid = 1'b0;
  endtask

  task automatic press_op(input logic [2:0] o);
    op_valid = 1'b1; button_op = o;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic press_eq();
    equal = 1'b1;
    @(negedge clk);
    equal = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic type_num(input int v);
    int tmp;
    int ds[$];
    tmp = v;
    do begin
      ds.push_front(tmp % 10);
      tmp = tmp / 10;
    end while (tmp > 0);
    foreach (ds[i]) press_num(4'(ds[i]));
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (busy === 1'b0) else begin
      errors++;
      $error("FAIL %s observed=busy_after_%0d_cycles expected=idle", tag, n);
    end
  endtask

  initial begin
    int cycles;
    int a, b;
    clear = 1'b1; num_valid = 1'b0; op_valid = 1'b0; equal = 1'b0;
    button_num = '0; button_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;

    exp_q.push_back('0); check("reset_result", result);
    exp_q.push_back('0); check("reset_result_temp", result_temp);
    exp_q.push_back('0); check("reset_busy", W'(busy));
    exp_q.push_back('0); check("reset_error", W'(error));

    // 12 + 34 = 46
    press_num(1); press_num(2);
    exp_q.push_back(16'd12); check("t1_entry", result_temp);
    press_op(3'b001);
    exp_q.push_back(16'd12); check("t1_acc", result_temp);
    press_num(3); press_num(4);
    exp_q.push_back(16'd46);
    press_eq();
    check("t1_result", result);
    exp_q.push_back(16'd46); check("t1_result_temp", result_temp);
    exp_q.push_back('0); check("t1_busy", W'(busy));

    // 5 - 3 + 2 = 4, then 3 - 5 wraps
    press_num(5); press_op(3'b010); press_num(3); press_op(3'b001);
    exp_q.push_back(16'd2); check("t2_chain", result_temp);
    press_num(2);
    exp_q.push_back(16'd4);
    press_eq();
    check("t2_result", result);
    press_num(3); press_op(3'b010); press_num(5);
    exp_q.push_back(16'hFFFE);
    press_eq();
    check("t2_wrap", result);

    // 6 / 3 with busy-phase length, then * 8
    press_num(6); press_op(3'b100); press_num(3);
    press_eq();
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    exp_q.push_back(W'(16)); check("t3_busy_cycles", W'(cycles));
    exp_q.push_back(16'd2); check("t3_quotient", result);
    press_op(3'b011); press_num(8);
    exp_q.push_back(16'd16);
    press_eq();
    check("t3_chain_mul", result);

    // divide by zero is sticky until clear
    press_num(7); press_op(3'b100); press_num(0);
    press_eq();
    exp_q.push_back(1); check("t4_error", W'(error));
    exp_q.push_back('0); check("t4_result", result);
    exp_q.push_back('0); check("t4_busy", W'(busy));
    press_num(4); press_op(3'b001);
    exp_q.push_back('0); check("t4_ignored_temp", result_temp);
    exp_q.push_back(1); check("t4_still_error", W'(error));
    do_clear();
    exp_q.push_back('0); check("t4_clear_error", W'(error));
    exp_q.push_back('0); check("t4_clear_temp", result_temp);

    // digit limit and operator replacement
    press_num(1); press_num(2); press_num(3); press_num(4); press_num(5);
    exp_q.push_back(16'd1234); check("t5_max_digits", result_temp);
    press_op(3'b001); press_op(3'b010); press_op(3'b011);
    exp_q.push_back(16'd1234); check("t5_acc", result_temp);
    press_num(2);
    exp_q.push_back(16'd2468);
    press_eq();
    check("t5_last_op", result);

    // clear during division, and clear beating a digit
    press_num(6); press_op(3'b100); press_num(3); press_eq();
    repeat (4) @(negedge clk);
    exp_q.push_back(1); check("t6_busy_mid", W'(busy));
    do_clear();
    exp_q.push_back('0); check("t6_busy", W'(busy));
    exp_q.push_back('0); check("t6_result", result);
    exp_q.push_back('0); check("t6_temp", result_temp);
    clear = 1'b1; num_valid = 1'b1; button_num = 4'd9;
    @(negedge clk);
    clear = 1'b0; num_valid = 1'b0;
    exp_q.push_back('0); check("t6_clear_beats_digit", result_temp);
    press_num(7);
    exp_q.push_back(16'd7); check("t6_digit_after", result_temp);
    press_eq();

    // randomised add and divide
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(0, 9999);
      b = $urandom_range(0, 9999);
      type_num(a); press_op(3'b001); type_num(b);
      exp_q.push_back(W'(a + b));
      press_eq();
      check("rand_add", result);
      a = $urandom_range(0, 9999);
      b = $urandom_range(1, 9999);
      type_num(a); press_op(3'b100); type_num(b);
      exp_q.push_back(W'(a / b));
      press_eq();
      wait_idle("rand_div_idle");
      check("rand_div", result);
    end

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
